// File: rtl/mem_access_if.sv
// Data-memory request/grant/response bus between the memory stage and the memory.
interface mem_access_if;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_gnt;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_gnt, mem_rvalid, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_gnt, mem_rvalid, mem_rdata
   );
endinterface

// File: rtl/mem_access.sv
// Memory-access pipeline stage: issues loads/stores on the data bus, stalls
// upstream while an access is outstanding, and emits a registered writeback record.
module mem_access #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic              write_reg,
   input  logic              load_en,
   input  logic              store_en,
   input  logic [31:0]       addr,
   input  logic [31:0]       data,
   input  logic [31:0]       res,
   input  logic [4:0]        rd,
   output logic              stall,
   mem_access_if.master      mem,
   output logic              wb_valid,
   output logic              wb_en,
   output logic [4:0]        wb_rd,
   output logic [31:0]       wb_data,
   output logic              misalign,
   output logic              timeout
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

   state_t           state, state_d;
   logic [CNT_W-1:0] cnt, cnt_d;
   logic [4:0]       lat_rd, lat_rd_d;
   logic             lat_wr, lat_wr_d;
   logic             req_d, we_d;
   logic [31:0]      addr_d, wdata_d;
   logic             wb_valid_d, wb_en_d, mis_d, to_d;
   logic [4:0]       wb_rd_d;
   logic [31:0]      wb_data_d;
   logic             is_mem, is_store;

   // Load wins when both request flags are set.
   assign is_mem   = load_en | store_en;
   assign is_store = store_en & ~load_en;

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         cnt           <= '0;
         lat_rd        <= '0;
         lat_wr        <= 1'b0;
         mem.mem_req   <= 1'b0;
         mem.mem_we    <= 1'b0;
         mem.mem_addr  <= '0;
         mem.mem_wdata <= '0;
         wb_valid      <= 1'b0;
         wb_en         <= 1'b0;
         wb_rd         <= '0;
         wb_data       <= '0;
         misalign      <= 1'b0;
         timeout       <= 1'b0;
      end else begin
         state         <= state_d;
         cnt           <= cnt_d;
         lat_rd        <= lat_rd_d;
         lat_wr        <= lat_wr_d;
         mem.mem_req   <= req_d;
         mem.mem_we    <= we_d;
         mem.mem_addr  <= addr_d;
         mem.mem_wdata <= wdata_d;
         wb_valid      <= wb_valid_d;
         wb_en         <= wb_en_d;
         wb_rd         <= wb_rd_d;
         wb_data       <= wb_data_d;
         misalign      <= mis_d;
         timeout       <= to_d;
      end
   end

   // Next state, next registered outputs and combinational stall.
   always_comb begin
      state_d    = state;
      cnt_d      = cnt;
      lat_rd_d   = lat_rd;
      lat_wr_d   = lat_wr;
      req_d      = mem.mem_req;
      we_d       = mem.mem_we;
      addr_d     = mem.mem_addr;
      wdata_d    = mem.mem_wdata;
      wb_valid_d = 1'b0;
      wb_en_d    = 1'b0;
      wb_rd_d    = wb_rd;
      wb_data_d  = wb_data;
      mis_d      = 1'b0;
      to_d       = 1'b0;
      stall      = 1'b0;

      case (state)
         IDLE: begin
            cnt_d = '0;
            if (in_valid) begin
               if (!is_mem) begin
                  wb_valid_d = 1'b1;
                  wb_en_d    = write_reg;
                  wb_rd_d    = rd;
                  wb_data_d  = res;
               end else if (addr[1:0] != 2'b00) begin
                  mis_d      = 1'b1;
                  wb_valid_d = 1'b1;
               end else begin
                  stall    = 1'b1;
                  state_d  = REQ;
                  lat_rd_d = rd;
                  lat_wr_d = write_reg;
                  req_d    = 1'b1;
                  we_d     = is_store;
                  addr_d   = addr;
                  wdata_d  = data;
               end
            end
         end
         REQ: begin
            cnt_d = cnt + CNT_W'(1);
            stall = 1'b1;
            if (mem.mem_gnt) begin
               req_d = 1'b0;
               if (mem.mem_we) begin
                  stall      = 1'b0;
                  wb_valid_d = 1'b1;
                  state_d    = IDLE;
               end else if (mem.mem_rvalid) begin
                  stall      = 1'b0;
                  wb_valid_d = 1'b1;
                  wb_en_d    = lat_wr;
                  wb_rd_d    = lat_rd;
                  wb_data_d  = mem.mem_rdata;
                  state_d    = IDLE;
               end else begin
                  state_d = RESP;
               end
            end
         end
         RESP: begin
            cnt_d = cnt + CNT_W'(1);
            stall = 1'b1;
            if (mem.mem_rvalid) begin
               stall      = 1'b0;
               wb_valid_d = 1'b1;
               wb_en_d    = lat_wr;
               wb_rd_d    = lat_rd;
               wb_data_d  = mem.mem_rdata;
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Abort an access still pending in its last allowed cycle; a completion wins.
      if (state != IDLE && stall && cnt == CNT_LAST) begin
         stall      = 1'b0;
         to_d       = 1'b1;
         wb_valid_d = 1'b1;
         wb_en_d    = 1'b0;
         req_d      = 1'b0;
         state_d    = IDLE;
      end
   end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access with a writeback scoreboard.
module tb_mem_access;

   typedef struct packed {
      logic        en;
      logic [4:0]  rd;
      logic [31:0] data;
      logic        mis;
      logic        to;
   } wb_exp_t;

   logic        clk, rst;
   logic        in_valid, write_reg, load_en, store_en;
   logic [31:0] addr, data, res;
   logic [4:0]  rd;
   logic        stall, wb_valid, wb_en, misalign, timeout;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;

   mem_access_if bus ();

   mem_access #(.TIMEOUT(16)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .write_reg(write_reg),
      .load_en(load_en), .store_en(store_en), .addr(addr), .data(data),
      .res(res), .rd(rd), .stall(stall), .mem(bus), .wb_valid(wb_valid),
      .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .misalign(misalign),
      .timeout(timeout)
   );

   wb_exp_t sb[$];
   int total = 0;
   int bad   = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one clock, then check the writeback record against the scoreboard.
   task automatic tick(input bit exp_wb);
      wb_exp_t e;
      @(posedge clk);
      #1;
      chk("wb_valid", 32'(wb_valid), 32'(exp_wb));
      if (wb_valid === 1'b1) begin
         chk("sb_underflow", 32'(sb.size() == 0), 32'd0);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("wb_en", 32'(wb_en), 32'(e.en));
            chk("misalign", 32'(misalign), 32'(e.mis));
            chk("timeout", 32'(timeout), 32'(e.to));
            if (e.en) begin
               chk("wb_rd", 32'(wb_rd), 32'(e.rd));
               chk("wb_data", wb_data, e.data);
            end
         end
      end else begin
         chk("misalign_idle", 32'(misalign), 32'd0);
         chk("timeout_idle", 32'(timeout), 32'd0);
      end
   endtask

   task automatic drive(input logic v, input logic wr, input logic ld, input logic st,
                        input logic [31:0] a, input logic [31:0] d, input logic [31:0] r,
                        input logic [4:0] rdi);
      in_valid  = v;
      write_reg = wr;
      load_en   = ld;
      store_en  = st;
      addr      = a;
      data      = d;
      res       = r;
      rd        = rdi;
   endtask

   task automatic push(input logic en, input logic [4:0] r, input logic [31:0] d,
                       input logic mis, input logic to);
      wb_exp_t e;
      e.en = en; e.rd = r; e.data = d; e.mis = mis; e.to = to;
      sb.push_back(e);
   endtask

   task automatic chk_stall(input string tag, input logic exp);
      #1;
      chk(tag, 32'(stall), 32'(exp));
   endtask

   initial begin
      rst = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
      tick(0);
      tick(0);
      chk("rst_mem_req", 32'(bus.mem_req), 0);
      chk("rst_mem_we", 32'(bus.mem_we), 0);
      chk("rst_mem_addr", bus.mem_addr, 0);
      chk("rst_mem_wdata", bus.mem_wdata, 0);
      chk("rst_wb_en", 32'(wb_en), 0);
      chk("rst_wb_rd", 32'(wb_rd), 0);
      chk("rst_wb_data", wb_data, 0);
      rst = 1'b0;

      // ALU passthrough, back to back
      drive(1, 1, 0, 0, 32'h0, 32'h0, 32'h1234, 5'd5);
      push(1, 5'd5, 32'h1234, 0, 0);
      chk_stall("alu_stall0", 0);
      tick(1);
      drive(1, 1, 0, 0, 32'h0, 32'h0, 32'hA5A5_0001, 5'd9);
      push(1, 5'd9, 32'hA5A5_0001, 0, 0);
      chk_stall("alu_stall1", 0);
      tick(1);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      tick(0);

      // Store, grant on the third request cycle
      drive(1, 0, 0, 1, 32'h100, 32'hDEAD_BEEF, 32'h0, 5'd3);
      push(0, 5'd0, 32'h0, 0, 0);
      chk_stall("st_stall_idle", 1);
      tick(0);
      for (int k = 0; k < 3; k++) begin
         bus.mem_gnt = (k == 2);
         chk("st_req", 32'(bus.mem_req), 1);
         chk("st_we", 32'(bus.mem_we), 1);
         chk("st_addr", bus.mem_addr, 32'h100);
         chk("st_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
         chk_stall("st_stall_req", k != 2);
         tick(k == 2);
      end
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      bus.mem_gnt = 1'b0;
      chk("st_req_drop", 32'(bus.mem_req), 0);

      // Load, read data three cycles after grant
      drive(1, 1, 1, 0, 32'h40, 32'h0, 32'h0, 5'd7);
      push(1, 5'd7, 32'hCAFE_F00D, 0, 0);
      chk_stall("ld_stall_idle", 1);
      tick(0);
      chk("ld_req", 32'(bus.mem_req), 1);
      chk("ld_we", 32'(bus.mem_we), 0);
      chk("ld_addr", bus.mem_addr, 32'h40);
      bus.mem_gnt = 1'b1;
      chk_stall("ld_stall_gnt", 1);
      tick(0);
      bus.mem_gnt = 1'b0;
      chk("ld_req_after_gnt", 32'(bus.mem_req), 0);
      chk_stall("ld_stall_resp1", 1);
      tick(0);
      chk_stall("ld_stall_resp2", 1);
      tick(0);
      bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hCAFE_F00D;
      chk_stall("ld_stall_rvalid", 0);
      tick(1);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      // rvalid in IDLE must not produce a writeback
      tick(0);
      bus.mem_rvalid = 1'b0;

      // Load and store both set: treated as a load; grant and rvalid together
      drive(1, 1, 1, 1, 32'hC0, 32'h5555_5555, 32'h0, 5'd12);
      push(1, 5'd12, 32'h0BAD_F00D, 0, 0);
      chk_stall("ldst_stall_idle", 1);
      tick(0);
      chk("ldst_we", 32'(bus.mem_we), 0);
      bus.mem_gnt = 1'b1; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h0BAD_F00D;
      chk_stall("ldst_stall_done", 0);
      tick(1);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0;
      chk("ldst_req_drop", 32'(bus.mem_req), 0);

      // Misaligned load is dropped without bus activity
      drive(1, 1, 1, 0, 32'h42, 32'h0, 32'h0, 5'd4);
      push(0, 5'd0, 32'h0, 1, 0);
      chk_stall("mis_stall", 0);
      tick(1);
      chk("mis_req", 32'(bus.mem_req), 0);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      tick(0);
      chk("mis_req2", 32'(bus.mem_req), 0);

      // Timeout: granted load whose data never returns
      drive(1, 1, 1, 0, 32'h44, 32'h0, 32'h0, 5'd4);
      push(0, 5'd0, 32'h0, 0, 1);
      chk_stall("to_stall_idle", 1);
      tick(0);
      for (int k = 0; k < 16; k++) begin
         bus.mem_gnt = (k == 0);
         chk_stall("to_stall", k != 15);
         tick(k == 15);
      end
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      bus.mem_gnt = 1'b0;
      chk("to_req", 32'(bus.mem_req), 0);
      drive(1, 1, 0, 0, 32'h0, 32'h0, 32'h77, 5'd1);
      push(1, 5'd1, 32'h77, 0, 0);
      chk_stall("to_next_stall", 0);
      tick(1);
      drive(0, 0, 0, 0, 0, 0, 0, 0);

      // Reset while waiting for read data
      drive(1, 1, 1, 0, 32'h50, 32'h0, 32'h0, 5'd8);
      tick(0);
      bus.mem_gnt = 1'b1;
      tick(0);
      bus.mem_gnt = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      rst = 1'b1;
      tick(0);
      rst = 1'b0;
      chk("mrst_req", 32'(bus.mem_req), 0);
      chk("mrst_we", 32'(bus.mem_we), 0);
      chk("mrst_addr", bus.mem_addr, 0);
      chk("mrst_wdata", bus.mem_wdata, 0);
      chk("mrst_wb_en", 32'(wb_en), 0);
      chk("mrst_wb_rd", 32'(wb_rd), 0);
      chk("mrst_wb_data", wb_data, 0);
      bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h1357_9BDF;
      tick(0);
      bus.mem_rvalid = 1'b0;
      drive(1, 1, 0, 0, 32'h0, 32'h0, 32'hFFFF_0000, 5'd31);
      push(1, 5'd31, 32'hFFFF_0000, 0, 0);
      chk_stall("mrst_next_stall", 0);
      tick(1);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      tick(0);

      chk("sb_drained", 32'(sb.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Memory-access pipeline stage. Consumes the execute stage's load/store requests (write_reg, load_en, store_en, addr, data) and its ALU result.
- Drives a request/grant/response data-memory bus and stalls upstream while an access is outstanding.
- Delivers a registered writeback record (valid, enable, rd, data) to the register-file writeback stage.

Parameters:
TIMEOUT, 16, max cycles an access may spend in REQ+RESP before abort (>=2)

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  execute-stage output valid
write_reg  input  1  instruction writes a register
load_en  input  1  load request
store_en  input  1  store request
addr  input  32  byte address for load/store
data  input  32  store data
res  input  32  ALU result for non-memory ops
rd  input  5  destination register index
stall  output  1  hold upstream stage (combinational)
mem_req  output  1  bus request
mem_we  output  1  1=write, 0=read
mem_addr  output  32  bus address
mem_wdata  output  32  bus write data
mem_gnt  input  1  request accepted this cycle
mem_rvalid  input  1  read data valid this cycle
mem_rdata  input  32  read data
wb_valid  output  1  writeback record valid (1-cycle pulse)
wb_en  output  1  writeback enables register write
wb_rd  output  5  writeback register index
wb_data  output  32  writeback data
misalign  output  1  1-cycle pulse: misaligned access dropped
timeout  output  1  1-cycle pulse: access aborted by timeout

Behaviour:
- Reset: state=IDLE, counter=0. All registered outputs 0: mem_req, mem_we, mem_addr, mem_wdata, wb_*, misalign, timeout. Reset mid-access drops mem_req on the next cycle and produces no wb_valid.
- States: IDLE, REQ, RESP.
- Input consumption:
  - In IDLE, an op is consumed on an edge with in_valid=1.
  - In REQ/RESP, inputs are ignored; latched copies are used instead.
  - Upstream advances on any edge where stall=0.
- Op classification: mem op = load_en|store_en. If both are set, it is a load (store_en ignored).
- IDLE, in_valid, non-mem op:
  - Next cycle: wb_valid=1, wb_en=write_reg, wb_rd=rd, wb_data=res.
  - stall=0.
- IDLE, in_valid, mem op, addr[1:0]!=0:
  - Next cycle: misalign=1, wb_valid=1, wb_en=0.
  - No bus activity; stall=0.
- IDLE, in_valid, aligned mem op:
  - stall=1 combinationally.
  - Latch addr, data, rd, write_reg, we=store. Next state REQ, counter=0.
- REQ:
  - mem_req=1; mem_we/mem_addr/mem_wdata held stable until grant. stall=1 except in the completion cycle.
  - On mem_gnt with store: complete. Next cycle wb_valid=1, wb_en=0; state IDLE.
  - On mem_gnt with load: go to RESP. If mem_rvalid is also 1 in the same cycle, complete the load immediately.
  - mem_req deasserts the cycle after grant.
- RESP:
  - mem_req=0.
  - On mem_rvalid: next cycle wb_valid=1, wb_en=latched write_reg, wb_rd=latched rd, wb_data=mem_rdata; state IDLE.
  - mem_rvalid is ignored in IDLE.
- Completion cycle (grant for store, rvalid for load, or timeout): stall=0, so upstream advances at that edge. The next op is evaluated in IDLE on the following cycle. Throughput: one memory op per ≥2 cycles; one non-mem op per cycle.
- Timeout:
  - Counter increments each cycle in REQ or RESP.
  - When counter==TIMEOUT-1 and the access has not completed: that cycle is the completion cycle (stall=0). Next cycle: timeout=1, wb_valid=1, wb_en=0, mem_req=0, state IDLE.
  - A completion in that same cycle wins over timeout.
- Not registered: stall (combinational). All other wb_*/misalign/timeout outputs are registered, 1-cycle pulses, and hold 0 otherwise. wb_rd/wb_data keep their last value when wb_valid=0.
- Arithmetic: all 32-bit, no extension. Word accesses only.

Test Plan:
- ALU passthrough: in_valid=1, write_reg=1, res=0x1234, rd=5 → next cycle wb_valid=1, wb_en=1, wb_rd=5, wb_data=0x1234; stall never 1.
- Store, grant delayed 2 cycles: store addr=0x100, data=0xDEADBEEF → mem_req/mem_we=1 with addr 0x100 and wdata held 3 cycles. stall=1 until the grant cycle. Next cycle wb_valid=1, wb_en=0.
- Load, rvalid 3 cycles after grant: load addr=0x40, rd=7, mem_rdata=0xCAFEF00D → wb_valid=1, wb_en=1, wb_rd=7, wb_data=0xCAFEF00D the cycle after rvalid. Also check same-cycle gnt+rvalid completes in one bus cycle.
- Misaligned: load addr=0x42 → mem_req never asserted; next cycle misalign=1, wb_valid=1, wb_en=0; stall=0.
- Timeout: load with mem_gnt=1 but mem_rvalid stuck 0 → abort after 16 cycles in REQ+RESP; timeout=1, wb_valid=1, wb_en=0; the next op is accepted normally.
- Reset mid-op: assert rst while in RESP → next cycle all outputs 0, state IDLE, no wb_valid. A following non-mem op completes normally.
